hamming_scrub_ctrl: RTL and testbench

Memory scrubber controller for the Hamming(7,4) datapath. When `start` is pulsed, it walks every address of a codeword memory once. For each word it reads the stored 7-bit codeword and computes the syndrome. If the syndrome is non-zero, it writes back the single-bit-corrected codeword. The memory port is shared with functional traffic, so each access waits on a request/grant handshake. Error statistics are exposed for software.

---
 rtl/hamming_pkg.sv | 15 +
 rtl/hamming74_syndrome.sv | 22 ++
 rtl/hamming_scrub_ctrl.sv | 115 +++++++++++
 tb/tb_hamming_scrub_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared state encoding and widths for the Hamming(7,4) scrubber.
package hamming_pkg;

  localparam int CW_W  = 7;
  localparam int SYN_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CHK,
    S_WR,
    S_DONE
  } state_e;

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational Hamming(7,4) syndrome and single-bit correction.
module hamming74_syndrome
  import hamming_pkg::*;
(
  input  logic [1:CW_W]    cw_i,
  output logic [SYN_W-1:0] syndrome_o,
  output logic [1:CW_W]    corrected_o
);

  assign syndrome_o[2] = cw_i[4] ^ cw_i[5] ^ cw_i[6] ^ cw_i[7];
  assign syndrome_o[1] = cw_i[2] ^ cw_i[3] ^ cw_i[6] ^ cw_i[7];
  assign syndrome_o[0] = cw_i[1] ^ cw_i[3] ^ cw_i[5] ^ cw_i[7];

  // A non-zero syndrome is the position of the bit to invert.
  always_comb begin
    corrected_o = cw_i;
    for (int i = 1; i <= CW_W; i++) begin
      corrected_o[i] = cw_i[i] ^ (syndrome_o == SYN_W'(i));
    end
  end

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Memory scrubber: walks every codeword once, rewrites single-bit-corrected
// words through a request/grant shared port and keeps error statistics.
module hamming_scrub_ctrl
  import hamming_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [1:CW_W]     mem_rd_data,
  output logic              mem_wr_en,
  output logic [1:CW_W]     mem_wr_data,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] last_err_addr,
  output logic [SYN_W-1:0]  last_syndrome
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [1:CW_W]     wr_data_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  err_cnt_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [SYN_W-1:0]  last_syn_q;
  logic [SYN_W-1:0]  syn;
  logic [1:CW_W]     corr;
  logic              last_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  hamming74_syndrome u_syndrome (
    .cw_i        (mem_rd_data),
    .syndrome_o  (syn),
    .corrected_o (corr)
  );

  assign addr_d    = addr_q + ADDR_W'(1);
  assign err_cnt_d = sat_inc(err_cnt_q);
  assign last_word = &addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wr_data_q   <= '0;
      err_cnt_q   <= '0;
      last_addr_q <= '0;
      last_syn_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q    <= '0;
            err_cnt_q <= '0;
            state_q   <= S_RD;
          end
        end
        S_RD: begin
          if (mem_gnt) state_q <= S_CHK;
        end
        // Read data arrives exactly one cycle after the granted read.
        S_CHK: begin
          if (syn != '0) begin
            wr_data_q   <= corr;
            last_addr_q <= addr_q;
            last_syn_q  <= syn;
            err_cnt_q   <= err_cnt_d;
            state_q     <= S_WR;
          end else if (last_word) begin
            state_q <= S_DONE;
          end else begin
            addr_q  <= addr_d;
            state_q <= S_RD;
          end
        end
        S_WR: begin
          if (mem_gnt) begin
            if (last_word) begin
              state_q <= S_DONE;
            end else begin
              addr_q  <= addr_d;
              state_q <= S_RD;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes are qualified by grant so a stalled access never fires.
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign mem_req       = (state_q == S_RD) || (state_q == S_WR);
  assign mem_rd_en     = (state_q == S_RD) && mem_gnt;
  assign mem_wr_en     = (state_q == S_WR) && mem_gnt;
  assign mem_addr      = addr_q;
  assign mem_wr_data   = wr_data_q;
  assign err_count     = err_cnt_q;
  assign last_err_addr = last_addr_q;
  assign last_syndrome = last_syn_q;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Bench for hamming_scrub_ctrl: transaction-level model of a scrub pass
// (expected reads, corrected writes, latency, statistics) with a per-cycle monitor.
module tb_hamming_scrub_ctrl;

  localparam int AW  = 4;
  localparam int N   = 16;
  localparam int AWB = 3;
  localparam int NB  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: ADDR_W=4, CNT_W=8
  logic          start, busy, done, mem_req, mem_gnt, mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr, last_err_addr;
  logic [1:7]    mem_rd_data, mem_wr_data;
  logic [7:0]    err_count;
  logic [2:0]    last_syndrome;

  // DUT B: ADDR_W=3, CNT_W=2
  logic           b_start, b_busy, b_done, b_mem_req, b_mem_gnt, b_mem_rd_en, b_mem_wr_en;
  logic [AWB-1:0] b_mem_addr, b_last_err_addr;
  logic [1:7]     b_mem_rd_data, b_mem_wr_data;
  logic [1:0]     b_err_count;
  logic [2:0]     b_last_syndrome;

  hamming_scrub_ctrl #(.ADDR_W(AW), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .err_count(err_count), .last_err_addr(last_err_addr), .last_syndrome(last_syndrome)
  );

  hamming_scrub_ctrl #(.ADDR_W(AWB), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .mem_req(b_mem_req), .mem_gnt(b_mem_gnt), .mem_addr(b_mem_addr),
    .mem_rd_en(b_mem_rd_en), .mem_rd_data(b_mem_rd_data),
    .mem_wr_en(b_mem_wr_en), .mem_wr_data(b_mem_wr_data),
    .err_count(b_err_count), .last_err_addr(b_last_err_addr), .last_syndrome(b_last_syndrome)
  );

  // Memories with 1-cycle read latency; images are loaded by a one-cycle load pulse
  logic [1:7] mem [N];
  logic [1:7] img [N];
  logic [1:7] gold [N];
  logic [1:7] rd_q = '0;
  logic       load = 1'b0;
  logic [1:7] mem_b [NB];
  logic [1:7] img_b [NB];
  logic [1:7] gold_b [NB];
  logic [1:7] rd_b_q = '0;
  logic       load_b = 1'b0;
  int         b_wr_cnt = 0;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) begin
      for (int i = 0; i < N; i++) mem[i] <= img[i];
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
    end
    if (mem_rd_en) rd_q <= mem[mem_addr];
    if (load_b) begin
      for (int i = 0; i < NB; i++) mem_b[i] <= img_b[i];
    end else if (b_mem_wr_en) begin
      mem_b[b_mem_addr] <= b_mem_wr_data;
    end
    if (b_mem_rd_en) rd_b_q <= mem_b[b_mem_addr];
    if (b_mem_wr_en) b_wr_cnt <= b_wr_cnt + 1;
  end
  assign mem_rd_data   = rd_q;
  assign b_mem_rd_data = rd_b_q;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Reference model: encoding and syndrome straight from the codeword definition
  function automatic logic [1:7] enc(input logic [3:0] d);
    logic [1:7] c;
    c    = '0;
    c[3] = d[3]; c[5] = d[2]; c[6] = d[1]; c[7] = d[0];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    return c;
  endfunction

  function automatic int msyn(input logic [1:7] c);
    return 4 * int'(c[4] ^ c[5] ^ c[6] ^ c[7])
         + 2 * int'(c[2] ^ c[3] ^ c[6] ^ c[7])
         +     int'(c[1] ^ c[3] ^ c[5] ^ c[7]);
  endfunction

  // Monitor state and model expectations for the current pass
  bit         mon_on = 1'b0;
  int         rd_idx, stalls, dones, s_cyc;
  bit         hold_v;
  logic [3:0] hold_addr;
  logic [1:7] hold_wd;
  int         exp_a[$];
  logic [1:7] exp_d[$];
  int         m_last_addr = 0;
  int         m_last_syn = 0;

  task automatic monitor();
    int a;
    logic [1:7] d;
    forever begin
      @(negedge clk);
      if (mon_on && !rst) begin
        if (mem_req && !mem_gnt) stalls++;
        chk("strobe_without_grant", 32'((mem_rd_en | mem_wr_en) & !mem_gnt), 0);
        chk("strobe_without_req", 32'((mem_rd_en | mem_wr_en) & !mem_req), 0);
        chk("strobe_overlap", 32'(mem_rd_en & mem_wr_en), 0);
        if (hold_v) begin
          chk("stall_hold_addr", 32'(mem_addr), 32'(hold_addr));
          chk("stall_hold_wdata", 32'(mem_wr_data), 32'(hold_wd));
        end
        hold_v    = mem_req && !mem_gnt;
        hold_addr = mem_addr;
        hold_wd   = mem_wr_data;
        if (mem_rd_en) begin
          chk("read_addr_order", 32'(mem_addr), 32'(rd_idx));
          rd_idx++;
        end
        if (mem_wr_en) begin
          if (exp_a.size() == 0) begin
            chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
          end else begin
            a = exp_a.pop_front();
            d = exp_d.pop_front();
            chk("write_addr", 32'(mem_addr), 32'(a));
            chk("write_data", 32'(mem_wr_data), 32'(d));
          end
        end
        if (done) dones++;
      end
    end
  endtask

  task automatic prep_expect(output int e);
    int s;
    e = 0;
    exp_a.delete();
    exp_d.delete();
    for (int i = 0; i < N; i++) begin
      s = msyn(mem[i]);
      if (s != 0) begin
        exp_a.push_back(i);
        exp_d.push_back(gold[i]);
        e++;
        m_last_addr = i;
        m_last_syn  = s;
      end
    end
    rd_idx = 0; stalls = 0; dones = 0; hold_v = 1'b0;
  endtask

  task automatic load_mem();
    @(posedge clk); #2; load = 1'b1; load_b = 1'b1;
    @(posedge clk); #2; load = 1'b0; load_b = 1'b0;
  endtask

  // mode 0: grant high; 1: 3 stalls on RD of addr 2, 2 on WR of addr 5;
  // 2: random grant and random start while busy; 3: grant high, two starts while busy
  task automatic run_pass(input int mode, output int lat);
    int e, rd_st, wr_st, bad;
    bit seen5;
    rd_st = 3; wr_st = 2; seen5 = 1'b0;
    prep_expect(e);
    mon_on = 1'b1;
    lat = -1;
    @(posedge clk); #2; start = 1'b1; mem_gnt = 1'b1; s_cyc = cyc;
    @(posedge clk); #2; start = 1'b0;
    for (int i = 0; i < 4000 && lat < 0; i++) begin
      mem_gnt = 1'b1;
      if (mode == 1) begin
        if (mem_req && mem_addr == 4'd2 && rd_st > 0) begin
          mem_gnt = 1'b0; rd_st--;
        end else if (mem_req && mem_addr == 4'd5 && seen5 && wr_st > 0) begin
          mem_gnt = 1'b0; wr_st--;
        end
      end else if (mode == 2) begin
        mem_gnt = ($urandom_range(0, 3) != 0);
      end
      if (mode == 2) start = busy && ($urandom_range(0, 7) == 0);
      else if (mode == 3) start = (i == 5) || (i == 20);
      else start = 1'b0;
      @(negedge clk);
      if (mem_rd_en && mem_addr == 4'd5) seen5 = 1'b1;
      if (done) lat = cyc - s_cyc;
      else begin
        @(posedge clk); #2;
      end
    end
    start = 1'b0;
    mem_gnt = 1'b1;
    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    chk("done_seen", 32'(lat >= 0), 1);
    chk("done_pulse_count", 32'(dones), 1);
    chk("latency_rule", 32'(lat), 32'(2 * N + e + 1 + stalls));
    chk("pending_writes", 32'(exp_a.size()), 0);
    chk("reads_done", 32'(rd_idx), N);
    chk("err_count", 32'(err_count), 32'(e));
    chk("last_err_addr", 32'(last_err_addr), 32'(m_last_addr));
    chk("last_syndrome", 32'(last_syndrome), 32'(m_last_syn));
    chk("busy_after_pass", 32'(busy), 0);
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== gold[i]) bad++;
    chk("memory_clean", 32'(bad), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({busy, done, mem_req, mem_rd_en, mem_wr_en}), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wdata"}, 32'(mem_wr_data), 0);
    chk({tag, "_errcnt"}, 32'(err_count), 0);
    chk({tag, "_last"}, 32'({last_err_addr, last_syndrome}), 0);
  endtask

  initial begin
    int lat, e, blat, bad, w0;
    bit seen7, hit;
    logic [1:7] bad7;
    rst = 1'b1; start = 1'b0; mem_gnt = 1'b1; b_start = 1'b0; b_mem_gnt = 1'b1;
    fork monitor(); join_none
    for (int i = 0; i < N; i++) begin gold[i] = enc(4'b1011); img[i] = gold[i]; end
    for (int i = 0; i < NB; i++) begin gold_b[i] = '0; img_b[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset_b", 32'({b_busy, b_done, b_mem_req, b_err_count, b_mem_addr}), 0);
    #1; rst = 1'b0;

    chk("model_encode_1011", 32'(enc(4'b1011)), 32'(7'b0110011));
    chk("model_syndrome_c5", 32'(msyn(7'b0110111)), 5);

    // Clean memory
    load_mem();
    run_pass(0, lat);
    chk("t1_latency", 32'(lat), 33);
    chk("t1_err_count", 32'(err_count), 0);

    // Single error at address 5 (c5 flipped)
    img[5] = 7'b0110111;
    load_mem();
    run_pass(0, lat);
    chk("t2_latency", 32'(lat), 34);
    chk("t2_last_syndrome", 32'(last_syndrome), 5);
    chk("t2_last_err_addr", 32'(last_err_addr), 5);
    chk("t2_err_count", 32'(err_count), 1);
    chk("t2_mem5", 32'(mem[5]), 32'(7'b0110011));

    // Grant stalls: 3 on RD of addr 2, 2 on WR of addr 5
    load_mem();
    run_pass(1, lat);
    chk("t3_latency", 32'(lat), 39);
    chk("t3_stalls", 32'(stalls), 5);

    // Start pulsed while busy must be ignored
    load_mem();
    run_pass(3, lat);
    chk("t6_latency", 32'(lat), 34);

    // Reset during the WR of address 7
    img[5] = gold[5];
    img[3] = gold[3]; img[3][6] = ~img[3][6];
    img[7] = gold[7]; img[7][2] = ~img[7][2];
    bad7 = img[7];
    load_mem();
    prep_expect(e);
    mon_on = 1'b1;
    seen7 = 1'b0; hit = 1'b0;
    @(posedge clk); #2; start = 1'b1; mem_gnt = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      mem_gnt = !(seen7 && mem_req && mem_addr == 4'd7);
      if (!mem_gnt) hit = 1'b1;
      else begin
        @(negedge clk);
        if (mem_rd_en && mem_addr == 4'd7) seen7 = 1'b1;
        @(posedge clk); #2;
      end
    end
    chk("t5_reached_wr7", 32'(hit), 1);
    chk("t5_pending_wr7", 32'(mem_req), 1);
    #1; rst = 1'b1; mem_gnt = 1'b1;
    #1;
    chk_zero("t5_async_reset");
    @(negedge clk);
    chk("t5_no_strobe_in_reset", 32'({mem_rd_en, mem_wr_en}), 0);
    @(posedge clk); #2; rst = 1'b0; mon_on = 1'b0;
    #1;
    chk("t5_write_aborted", 32'(mem[7]), 32'(bad7));
    chk("t5_mem3_fixed_before_reset", 32'(mem[3]), 32'(gold[3]));
    m_last_addr = 0; m_last_syn = 0;
    run_pass(0, lat);
    chk("t5_rescan_latency", 32'(lat), 34);
    chk("t5_rescan_syndrome", 32'(last_syndrome), 2);

    // Randomized passes
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < N; i++) begin
        gold[i] = enc(4'($urandom_range(0, 15)));
        img[i]  = gold[i];
        if ($urandom_range(0, 2) == 0) begin
          w0 = $urandom_range(1, 7);
          img[i][w0] = ~img[i][w0];
        end
      end
      load_mem();
      run_pass((p % 2 == 0) ? 2 : 0, lat);
    end

    // Saturation on the small instance: every word corrupted
    for (int i = 0; i < NB; i++) begin
      gold_b[i] = enc(4'((i * 5 + 3) % 16));
      img_b[i]  = gold_b[i];
      w0 = (i % 7) + 1;
      img_b[i][w0] = ~img_b[i][w0];
    end
    load_mem();
    w0 = b_wr_cnt;
    @(posedge clk); #2; b_start = 1'b1; s_cyc = cyc;
    @(posedge clk); #2; b_start = 1'b0;
    blat = -1;
    for (int i = 0; i < 300 && blat < 0; i++) begin
      @(negedge clk);
      if (b_done) blat = cyc - s_cyc;
      else begin
        @(posedge clk); #2;
      end
    end
    @(negedge clk);
    chk("t4_latency", 32'(blat), 25);
    chk("t4_write_count", 32'(b_wr_cnt - w0), 8);
    chk("t4_err_count_saturated", 32'(b_err_count), 3);
    chk("t4_last_err_addr", 32'(b_last_err_addr), 7);
    chk("t4_last_syndrome", 32'(b_last_syndrome), 1);
    bad = 0;
    for (int i = 0; i < NB; i++) if (mem_b[i] !== gold_b[i]) bad++;
    chk("t4_memory_clean", 32'(bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
